// File: rtl/quad_encoder_emulator.sv
// Quadrature A/B generator that walks a signed position one count at a time toward
// a commanded target, with A/B edges never closer than STEP_DIV clocks apart.
module quad_encoder_emulator #(
  parameter int WIDTH    = 24,
  parameter int STEP_DIV = 100
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    enable,
  input  logic signed [WIDTH-1:0] target,
  input  logic                    load,
  input  logic signed [WIDTH-1:0] load_value,
  output logic                    quadA,
  output logic                    quadB,
  output logic signed [WIDTH-1:0] position,
  output logic                    busy,
  output logic                    dir
);

  localparam int DIV_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  // The {A,B} register is itself the phase, held in Gray order 00,10,11,01 so a
  // step only ever flips one output flop and the pins never glitch.
  logic [1:0]       ab;
  logic [DIV_W-1:0] divider;

  logic signed [WIDTH:0] tgt_x_p0;
  logic signed [WIDTH:0] pos_x_p0;
  logic signed [WIDTH:0] diff_p0;
  logic                  differ_p0;
  logic                  up_p0;
  logic                  move_p0;
  logic                  step_p0;

  function automatic logic [1:0] next_ab(input logic [1:0] cur, input logic up);
    logic [1:0] nxt;
    nxt = cur;
    if (up) begin
      case (cur)
        2'b00:   nxt = 2'b10;
        2'b10:   nxt = 2'b11;
        2'b11:   nxt = 2'b01;
        default: nxt = 2'b00;
      endcase
    end else begin
      case (cur)
        2'b00:   nxt = 2'b01;
        2'b01:   nxt = 2'b11;
        2'b11:   nxt = 2'b10;
        default: nxt = 2'b00;
      endcase
    end
    return nxt;
  endfunction

  // Step decision: one extra bit of headroom keeps the direction correct even
  // when target and position sit at opposite ends of the signed range.
  always_comb begin
    tgt_x_p0  = target;
    pos_x_p0  = position;
    diff_p0   = tgt_x_p0 - pos_x_p0;
    differ_p0 = (diff_p0 != '0);
    up_p0     = ~diff_p0[WIDTH];
    move_p0   = enable && !load && differ_p0;
    step_p0   = move_p0 && (divider == DIV_LAST);
  end

  // State update: load beats stepping; a stalled or arrived move parks the divider.
  always_ff @(posedge CLK) begin
    if (reset) begin
      position <= '0;
      ab       <= 2'b00;
      busy     <= 1'b0;
      dir      <= 1'b1;
      divider  <= '0;
    end else begin
      busy <= enable && differ_p0;
      if (load) begin
        position <= load_value;
        divider  <= '0;
      end else if (!move_p0) begin
        divider <= '0;
      end else if (step_p0) begin
        divider  <= '0;
        position <= up_p0 ? position + WIDTH'(1) : position - WIDTH'(1);
        ab       <= next_ab(ab, up_p0);
        dir      <= up_p0;
      end else begin
        divider <= divider + DIV_W'(1);
      end
    end
  end

  assign quadA = ab[1];
  assign quadB = ab[0];

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Scoreboard bench: directed moves queue expected A/B edges; a monitor pops them on
// every observed edge. A second instance closes the loop through a filtered decoder.
module tb_quad_encoder_emulator;

  localparam int W    = 24;
  localparam int FILT = 100;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic                reset, enable, load;
  logic signed [W-1:0] target, load_value;
  logic                quadA, quadB, busy, dir;
  logic signed [W-1:0] position;

  logic                enable2, load2;
  logic signed [W-1:0] target2, load_value2;
  logic                quadA2, quadB2, busy2, dir2;
  logic signed [W-1:0] position2;

  quad_encoder_emulator #(.WIDTH(W), .STEP_DIV(100)) dut (
    .CLK(CLK), .reset(reset), .enable(enable), .target(target), .load(load),
    .load_value(load_value), .quadA(quadA), .quadB(quadB), .position(position),
    .busy(busy), .dir(dir)
  );

  quad_encoder_emulator #(.WIDTH(W), .STEP_DIV(200)) dut2 (
    .CLK(CLK), .reset(reset), .enable(enable2), .target(target2), .load(load2),
    .load_value(load_value2), .quadA(quadA2), .quadB(quadB2), .position(position2),
    .busy(busy2), .dir(dir2)
  );

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         c;
    logic [1:0] ab;
    int         pos;
    logic       d;
  } edge_t;

  edge_t sb[$];

  task automatic push_edge(input int c, input logic [1:0] ab, input int pos, input logic d);
    edge_t e;
    e.c = c; e.ab = ab; e.pos = pos; e.d = d;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Edge monitor for the main instance
  logic [1:0] prev_ab = 2'b00;
  bit         mon_en  = 1'b0;
  edge_t      ev;
  always @(posedge CLK) begin
    #1;
    if (mon_en && ({quadA, quadB} != prev_ab)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_edge actual_ab=%b pos=%0d expected=no_edge (cycle %0d)",
                 {quadA, quadB}, position, cyc);
      end else begin
        ev = sb.pop_front();
        check("edge_cycle", cyc, ev.c);
        check("edge_ab", {quadA, quadB}, ev.ab);
        check("edge_pos", position, ev.pos);
        check("edge_dir", dir, ev.d);
        check("edge_onebit", $countones({quadA, quadB} ^ prev_ab), 1);
      end
    end
    prev_ab = {quadA, quadB};
  end

  // Reference quadrature decoder with a 100-clock input filter
  logic       fa, fb;
  logic [1:0] pf;
  int         fa_cnt, fb_cnt, dec_cnt;

  function automatic int qstep(input logic [1:0] p, input logic [1:0] c);
    case ({p, c})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: return 1;
      4'b1000, 4'b1110, 4'b0111, 4'b0001: return -1;
      default: return 0;
    endcase
  endfunction

  always @(posedge CLK) begin
    if (reset) begin
      fa <= 1'b0; fb <= 1'b0; pf <= 2'b00;
      fa_cnt <= 0; fb_cnt <= 0; dec_cnt <= 0;
    end else begin
      if (quadA2 != fa) begin
        if (fa_cnt == FILT - 1) begin fa <= quadA2; fa_cnt <= 0; end
        else fa_cnt <= fa_cnt + 1;
      end else fa_cnt <= 0;
      if (quadB2 != fb) begin
        if (fb_cnt == FILT - 1) begin fb <= quadB2; fb_cnt <= 0; end
        else fb_cnt <= fb_cnt + 1;
      end else fb_cnt <= 0;
      pf <= {fa, fb};
      if ({fa, fb} != pf) dec_cnt <= dec_cnt + qstep(pf, {fa, fb});
    end
  end

  task automatic cl_move(input int tgt);
    int i;
    target2 = W'(tgt);
    enable2 = 1'b1;
    wait_cyc(2);
    i = 0;
    while (busy2 && i < 40000) begin
      wait_cyc(1);
      i++;
    end
    check("cl_busy_fall", busy2, 0);
    wait_cyc(2 * FILT);
    check("cl_position", position2, tgt);
    check("cl_decoder", dec_cnt, tgt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; enable = 1'b0; load = 1'b0; target = '0; load_value = '0;
    enable2 = 1'b0; load2 = 1'b0; target2 = '0; load_value2 = '0;
    wait_cyc(3);
    check("rst_position", position, 0);
    check("rst_ab", {quadA, quadB}, 0);
    check("rst_busy", busy, 0);
    check("rst_dir", dir, 1);
    reset = 1'b0;
    mon_en = 1'b1;
    wait_cyc(2);

    // Up 0 -> 4
    n = cyc;
    target = 24'sd4; enable = 1'b1;
    push_edge(n + 100, 2'b10, 1, 1'b1);
    push_edge(n + 200, 2'b11, 2, 1'b1);
    push_edge(n + 300, 2'b01, 3, 1'b1);
    push_edge(n + 400, 2'b00, 4, 1'b1);
    wait_cyc(1);
    check("busy_rise", busy, 1);
    wait_cyc(404);
    check("up_final_pos", position, 4);
    check("up_busy_fall", busy, 0);

    // Down 4 -> -2
    n = cyc;
    target = -24'sd2;
    push_edge(n + 100, 2'b01, 3, 1'b0);
    push_edge(n + 200, 2'b11, 2, 1'b0);
    push_edge(n + 300, 2'b10, 1, 1'b0);
    push_edge(n + 400, 2'b00, 0, 1'b0);
    push_edge(n + 500, 2'b01, -1, 1'b0);
    push_edge(n + 600, 2'b11, -2, 1'b0);
    wait_cyc(605);
    check("down_final_pos", position, -2);
    check("down_dir", dir, 0);
    check("down_busy", busy, 0);

    // Reversal mid-move: toward 10, then -3 at +350
    n = cyc;
    target = 24'sd10;
    push_edge(n + 100, 2'b01, -1, 1'b1);
    push_edge(n + 200, 2'b00, 0, 1'b1);
    push_edge(n + 300, 2'b10, 1, 1'b1);
    push_edge(n + 400, 2'b00, 0, 1'b0);
    push_edge(n + 500, 2'b01, -1, 1'b0);
    push_edge(n + 600, 2'b11, -2, 1'b0);
    push_edge(n + 700, 2'b10, -3, 1'b0);
    wait_cyc(350);
    target = -24'sd3;
    wait_cyc(355);
    check("rev_final_pos", position, -3);

    // Load mid-move near the positive limit
    n = cyc;
    target = 24'sh7FFFFF;
    wait_cyc(50);
    load = 1'b1; load_value = 24'sh7FFFFE;
    wait_cyc(1);
    load = 1'b0;
    check("load_pos", position, 24'sh7FFFFE);
    check("load_ab_kept", {quadA, quadB}, 2'b10);
    check("load_dir_kept", dir, 0);
    push_edge(n + 151, 2'b11, 24'sh7FFFFF, 1'b1);
    wait_cyc(110);
    check("max_pos", position, 24'sh7FFFFF);
    check("max_busy", busy, 0);

    // Enable gap of 50 cycles starting at divider=60
    n = cyc;
    target = 24'sh7FFFFD;
    wait_cyc(60);
    enable = 1'b0;
    wait_cyc(5);
    check("gap_busy", busy, 0);
    wait_cyc(45);
    enable = 1'b1;
    push_edge(n + 210, 2'b10, 24'sh7FFFFE, 1'b0);
    push_edge(n + 310, 2'b00, 24'sh7FFFFD, 1'b0);
    wait_cyc(205);
    check("gap_final_pos", position, 24'sh7FFFFD);

    // Target returns to position before the step: no edge
    n = cyc;
    target = 24'sh7FFFFE;
    wait_cyc(90);
    target = 24'sh7FFFFD;
    wait_cyc(20);
    check("cancel_pos", position, 24'sh7FFFFD);
    check("cancel_busy", busy, 0);

    // Opposite extremes: min position, max target must step up
    n = cyc;
    load = 1'b1; load_value = -24'sd8388608; target = 24'sh7FFFFF;
    wait_cyc(1);
    load = 1'b0;
    check("min_load_pos", position, -8388608);
    push_edge(n + 101, 2'b10, -8388607, 1'b1);
    wait_cyc(149);
    target = -24'sd8388607;
    wait_cyc(100);
    check("extreme_pos", position, -8388607);
    check("extreme_busy", busy, 0);

    // Closed loop through the filtered decoder
    cl_move(60);
    cl_move(-40);
    cl_move(25);
    cl_move(-10);

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
